aes_sbox_seq: RTL
=================

// Module: aes_sbox_seq
// PURPOSE
//  Requester side of the S-Box en/out_req/out_ack/prd_we handshake. Streams NumBytes
//  masked state bytes serially through one shared aes_sbox instance (any SecSBoxImpl).
//  Fetches fresh PRD per byte from the PRNG and collects the substituted bytes and masks.
//  Sits between the cipher core datapath and the shared S-Box in area-reduced cores.
// PARAMETERS
//  NumBytes   16  bytes per job; legal range 1..16
//  ReusePrd   0   1: sbox_prd_o[27:8] = sbox_prd_i of previous byte, only [7:0] from PRNG
// PORTS
//  clk_i             in   1            clock
//  rst_i             in   1            synchronous reset, active-high
//  start_i           in   1            start job (sampled in IDLE only)
//  abort_i           in   1            synchronous abort, returns to IDLE
//  op_i              in   2            AES op (aes_pkg ciph_op), latched at start
//  state_i           in   8*NumBytes   masked input state, byte k = [8k+7:8k]
//  state_mask_i      in   8*NumBytes   input mask
//  busy_o            out  1            job in progress
//  done_o            out  1            one-cycle pulse, results valid
//  state_o           out  8*NumBytes   substituted masked state
//  state_mask_o      out  8*NumBytes   output mask
//  prd_req_o         out  1            PRNG request
//  prd_ack_i         in   1            PRNG ack, prd_i valid
//  prd_i             in   28           fresh randomness
//  sbox_en_o         out  1            to aes_sbox en_i
//  sbox_prd_we_o     out  1            to aes_sbox prd_we_i
//  sbox_out_req_i    in   1            from aes_sbox out_req_o
//  sbox_out_ack_o    out  1            to aes_sbox out_ack_i
//  sbox_op_o         out  2            to aes_sbox op_i
//  sbox_data_o/mask_o out 8            byte/mask under processing
//  sbox_prd_o        out  28           to aes_sbox prd_i
//  sbox_data_i/mask_i in  8            S-Box result
//  sbox_prd_i        in   20           S-Box prd_o (used only when ReusePrd=1)
// BEHAVIOUR
//  Reset: FSM=IDLE, idx=0, all outputs/registers 0 (state_o, state_mask_o, prd reg included).
//  FSM IDLE -> PRD -> FEED -> (PRD | DONE) -> IDLE; idx width $clog2(NumBytes), min 1.
//  IDLE: busy_o=0. start_i=1: latch op/state/mask, idx=0, -> PRD.
//  PRD: busy_o=1, prd_req_o=1. On prd_ack_i: prd_q<=prd_i (ReusePrd: {sbox_prd_q,prd_i[7:0]}),
//   -> FEED. prd_ack_i outside PRD is ignored.
//  FEED: sbox_en_o=1; sbox_prd_we_o=1 in first FEED cycle only; data/mask = byte idx.
//   sbox_out_ack_o = FEED & sbox_out_req_i (combinational, same cycle).
//   On ack: state_o/state_mask_o byte idx <= sbox_data_i/mask_i; sbox_prd_q <= sbox_prd_i;
//   idx==NumBytes-1 -> DONE else idx+1, -> PRD. en drops the cycle after ack.
//  DONE: done_o=1 exactly one cycle, busy_o=1, -> IDLE; results held until next start.
//  Latency: single-cycle S-Box + prd_ack_i tied 1 = 2 cycles/byte; done_o 2*NumBytes+1
//   cycles after start_i. Multi-cycle (DOM) S-Box stalls in FEED until out_req.
//  start_i while busy: ignored. abort_i (priority over start_i, any state): -> IDLE next
//   cycle, no done_o, state_o/state_mask_o/prd_q cleared to 0, all sbox/prd strobes 0.
//  Reset mid-job behaves as abort. rst_i has priority over abort_i.
//  sbox_op_o, sbox_prd_o stable for the whole FEED phase of a byte.
// STRUCTURE
//  aes_pkg: WidthPRDSBox (8), new WidthPRDSBoxFull=28, WidthPRDSBoxOut=20,
//   typedef enum aes_sbox_seq_e {SEQ_IDLE,SEQ_PRD,SEQ_FEED,SEQ_DONE}.
//  Single flat module; byte select mux and result demux inline; no sub-module.
//  Parent instantiates aes_sbox and wires sbox_* ports one-to-one.
// TESTING
//  1 LUT S-Box, prd_ack_i=1, state_i=0, mask=0, op=FWD -> state_o all 8'h63, done at cycle 33.
//  2 DOM S-Box, random masks -> state_o^state_mask_o == SBox(state_i^state_mask_i), ack only on out_req.
//  3 prd_ack_i delayed 3 cycles per byte -> prd_req_o held, no sbox_en_o until ack, results correct.
//  4 abort_i during byte 5 FEED -> IDLE next cycle, no done_o, state_o==0, sbox_en_o==0.
//  5 start_i pulsed while busy, then op=INV with state_i byte 8'h63 -> ignored; second job yields 8'h00.
//  6 ReusePrd=1 -> sbox_prd_o[27:8] of byte k+1 equals sbox_prd_i captured at ack of byte k.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions used by the serial S-Box requester.
// PRD widths, cipher op encoding and sequencer state type.
package aes_pkg;

    localparam int WidthPRDSBox     = 8;
    localparam int WidthPRDSBoxFull = 28;
    localparam int WidthPRDSBoxOut  = 20;

    typedef enum logic [1:0] {
        CIPH_FWD = 2'b01,
        CIPH_INV = 2'b10
    } ciph_op_e;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_PRD  = 2'd1,
        SEQ_FEED = 2'd2,
        SEQ_DONE = 2'd3
    } aes_sbox_seq_e;

endpackage

// File: rtl/aes_sbox_seq.sv
// Serial requester for one shared masked S-Box: streams NumBytes bytes
// through the en/out_req/out_ack/prd_we handshake with fresh PRD per byte.
module aes_sbox_seq
    import aes_pkg::*;
#(
    parameter int NumBytes = 16,
    parameter bit ReusePrd = 1'b0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic                        abort_i,
    input  logic [1:0]                  op_i,
    input  logic [8*NumBytes-1:0]       state_i,
    input  logic [8*NumBytes-1:0]       state_mask_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [8*NumBytes-1:0]       state_o,
    output logic [8*NumBytes-1:0]       state_mask_o,
    output logic                        prd_req_o,
    input  logic                        prd_ack_i,
    input  logic [27:0]                 prd_i,
    output logic                        sbox_en_o,
    output logic                        sbox_prd_we_o,
    input  logic                        sbox_out_req_i,
    output logic                        sbox_out_ack_o,
    output logic [1:0]                  sbox_op_o,
    output logic [7:0]                  sbox_data_o,
    output logic [7:0]                  sbox_mask_o,
    output logic [27:0]                 sbox_prd_o,
    input  logic [7:0]                  sbox_data_i,
    input  logic [7:0]                  sbox_mask_i,
    input  logic [19:0]                 sbox_prd_i
);

    localparam int SW   = 8 * NumBytes;
    localparam int IdxW = (NumBytes > 1) ? $clog2(NumBytes) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NumBytes - 1);

    aes_sbox_seq_e               st_q, st_d;
    logic [IdxW-1:0]             idx_q, idx_d;
    logic [1:0]                  op_q, op_d;
    logic [SW-1:0]               data_q, data_d;
    logic [SW-1:0]               dmask_q, dmask_d;
    logic [SW-1:0]               res_q, res_d;
    logic [SW-1:0]               rmask_q, rmask_d;
    logic [WidthPRDSBoxFull-1:0] prd_q, prd_d;
    logic [WidthPRDSBoxOut-1:0]  sprd_q, sprd_d;
    logic                        we_q, we_d;

    always_comb begin
        st_d    = st_q;
        idx_d   = idx_q;
        op_d    = op_q;
        data_d  = data_q;
        dmask_d = dmask_q;
        res_d   = res_q;
        rmask_d = rmask_q;
        prd_d   = prd_q;
        sprd_d  = sprd_q;
        we_d    = 1'b0;
        if (abort_i) begin
            st_d    = SEQ_IDLE;
            idx_d   = '0;
            res_d   = '0;
            rmask_d = '0;
            prd_d   = '0;
            sprd_d  = '0;
        end else begin
            unique case (st_q)
                SEQ_IDLE: begin
                    if (start_i) begin
                        op_d    = op_i;
                        data_d  = state_i;
                        dmask_d = state_mask_i;
                        idx_d   = '0;
                        st_d    = SEQ_PRD;
                    end
                end
                SEQ_PRD: begin
                    if (prd_ack_i) begin
                        // Reuse mode keeps the S-Box's own leftover randomness
                        prd_d = ReusePrd ? {sprd_q, prd_i[WidthPRDSBox-1:0]}
                                         : prd_i;
                        we_d  = 1'b1;
                        st_d  = SEQ_FEED;
                    end
                end
                SEQ_FEED: begin
                    if (sbox_out_req_i) begin
                        res_d[8*idx_q +: 8]   = sbox_data_i;
                        rmask_d[8*idx_q +: 8] = sbox_mask_i;
                        sprd_d = sbox_prd_i;
                        if (idx_q == IdxLast) begin
                            st_d = SEQ_DONE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                            st_d  = SEQ_PRD;
                        end
                    end
                end
                SEQ_DONE: begin
                    st_d = SEQ_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q    <= SEQ_IDLE;
            idx_q   <= '0;
            op_q    <= '0;
            data_q  <= '0;
            dmask_q <= '0;
            res_q   <= '0;
            rmask_q <= '0;
            prd_q   <= '0;
            sprd_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            st_q    <= st_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            data_q  <= data_d;
            dmask_q <= dmask_d;
            res_q   <= res_d;
            rmask_q <= rmask_d;
            prd_q   <= prd_d;
            sprd_q  <= sprd_d;
            we_q    <= we_d;
        end
    end

    assign busy_o         = (st_q != SEQ_IDLE);
    assign done_o         = (st_q == SEQ_DONE);
    assign prd_req_o      = (st_q == SEQ_PRD);
    assign sbox_en_o      = (st_q == SEQ_FEED);
    assign sbox_prd_we_o  = we_q;
    assign sbox_out_ack_o = sbox_en_o & sbox_out_req_i;
    assign sbox_op_o      = op_q;
    assign sbox_data_o    = data_q[8*idx_q +: 8];
    assign sbox_mask_o    = dmask_q[8*idx_q +: 8];
    assign sbox_prd_o     = prd_q;
    assign state_o        = res_q;
    assign state_mask_o   = rmask_q;

endmodule
